fetch_control: RTL and testbench

// - Fetch-stage controller; sits around the ProgramCounter register.
// - Generates the next Address fed back into the PC.
// - Captures the instruction read at PCResult into a small FIFO toward decode.
// - Decode side uses a valid/ready handshake.
// - Supports stall (FIFO full or decode back-pressure) and branch/jump redirect with flush.

---
 rtl/fetch_control.sv | 106 ++++++++++
 tb/tb_fetch_control.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/fetch_control.sv
// Fetch-stage controller: next-PC selection, instruction capture into a
// small FIFO, and a valid/ready handshake toward decode.
module fetch_control #(
   parameter int unsigned DEPTH        = 2,
   parameter logic [31:0] RESET_VECTOR = 32'h0,
   parameter logic [31:0] PC_INC       = 32'd4
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic [31:0]              PCResult,
   input  logic [31:0]              Instruction,
   input  logic                     RedirectValid,
   input  logic [31:0]              RedirectTarget,
   output logic [31:0]              Address,
   output logic                     DecValid,
   input  logic                     DecReady,
   output logic [31:0]              DecInstr,
   output logic [31:0]              DecPC,
   output logic [31:0]              DecPCPlus4,
   output logic [$clog2(DEPTH):0]   FifoCount,
   output logic                     MisalignErr
);

   localparam int unsigned AW   = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   count;
   logic [31:0]   mem_instr [DEPTH];
   logic [31:0]   mem_pc    [DEPTH];
   logic [31:0]   mem_pc4   [DEPTH];
   logic          push, pop, flush;

   assign DecValid   = (count != '0);
   assign pop        = DecValid & DecReady;
   assign flush      = (state == RUN) & RedirectValid;
   assign FifoCount  = count;
   // Head is read straight from registered storage, so a push is only visible next cycle.
   assign DecInstr   = mem_instr[rd_ptr];
   assign DecPC      = mem_pc[rd_ptr];
   assign DecPCPlus4 = mem_pc4[rd_ptr];

   // State register: IDLE for one cycle after reset, then RUN until reset.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state, push decision and next-PC mux (redirect > sequential > hold).
   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      Address   = RESET_VECTOR;
      if (state == IDLE) begin
         state_nxt = RUN;
      end else if (RedirectValid) begin
         Address = {RedirectTarget[31:2], 2'b00};
      end else if ((count < FULL) || pop) begin
         push    = 1'b1;
         Address = PCResult + PC_INC;
      end else begin
         Address = PCResult;
      end
   end

   // FIFO storage, pointers and occupancy; redirect flushes everything at once.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_instr[i] <= '0;
            mem_pc[i]    <= '0;
            mem_pc4[i]   <= '0;
         end
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem_instr[wr_ptr] <= Instruction;
            mem_pc[wr_ptr]    <= PCResult;
            mem_pc4[wr_ptr]   <= PCResult + PC_INC;
            wr_ptr            <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // One-cycle pulse after a redirect whose target is not word aligned.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) MisalignErr <= 1'b0;
      else        MisalignErr <= flush & (RedirectTarget[1:0] != 2'b00);
   end

endmodule

// File: tb/tb_fetch_control.sv
// Directed bench for fetch_control with a ProgramCounter model and a
// combinational instruction memory returning 0x1000_0000 + word index.
module tb_fetch_control;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [31:0] PCResult, Instruction, RedirectTarget, Address;
   logic        RedirectValid, DecValid, DecReady, MisalignErr;
   logic [31:0] DecInstr, DecPC, DecPCPlus4;
   logic [1:0]  FifoCount;

   int errors = 0;
   int checks = 0;

   fetch_control #(.DEPTH(2), .RESET_VECTOR(32'h0), .PC_INC(32'd4)) dut (
      .Clk(Clk), .Reset(Reset), .PCResult(PCResult), .Instruction(Instruction),
      .RedirectValid(RedirectValid), .RedirectTarget(RedirectTarget),
      .Address(Address), .DecValid(DecValid), .DecReady(DecReady),
      .DecInstr(DecInstr), .DecPC(DecPC), .DecPCPlus4(DecPCPlus4),
      .FifoCount(FifoCount), .MisalignErr(MisalignErr)
   );

   always #5 Clk = ~Clk;

   // ProgramCounter register around the DUT
   always @(posedge Clk or negedge Reset) begin
      if (!Reset) PCResult <= 32'h0;
      else        PCResult <= Address;
   end

   assign Instruction = 32'h1000_0000 + (PCResult >> 2);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      Reset = 1'b0; DecReady = 1'b1; RedirectValid = 1'b0; RedirectTarget = 32'h0;
      #1;
      check("rst_valid", {31'b0, DecValid}, 32'd0);
      check("rst_count", {30'b0, FifoCount}, 32'd0);
      check("rst_pc",    DecPC, 32'h0);
      check("rst_pc4",   DecPCPlus4, 32'h0);
      check("rst_instr", DecInstr, 32'h0);
      check("rst_mis",   {31'b0, MisalignErr}, 32'd0);
      #1 Reset = 1'b1;
      #1;
      check("idle_addr", Address, 32'h0);
      tick();                                      // now RUN, PC=0
      check("run0_valid", {31'b0, DecValid}, 32'd0);
      check("run0_addr",  Address, 32'h4);
      tick();
      check("s0_valid", {31'b0, DecValid}, 32'd1);
      check("s0_pc",    DecPC, 32'h0);
      check("s0_pc4",   DecPCPlus4, 32'h4);
      check("s0_instr", DecInstr, 32'h1000_0000);
      check("s0_count", {30'b0, FifoCount}, 32'd1);
      tick();
      check("s1_pc",    DecPC, 32'h4);
      check("s1_instr", DecInstr, 32'h1000_0001);
      tick();
      check("s2_pc",    DecPC, 32'h8);
      check("s2_instr", DecInstr, 32'h1000_0002);
      check("s2_count", {30'b0, FifoCount}, 32'd1);
      // back-pressure for 5 cycles
      DecReady = 1'b0;
      tick();
      check("bp_count", {30'b0, FifoCount}, 32'd2);
      check("bp_hold",  Address, 32'h10);
      check("bp_pcres", PCResult, 32'h10);
      tick(); tick(); tick(); tick();
      check("bp_count5", {30'b0, FifoCount}, 32'd2);
      check("bp_head5",  DecPC, 32'h8);
      check("bp_addr5",  Address, 32'h10);
      // release: full with pop pushes in the same cycle
      DecReady = 1'b1;
      #1;
      check("fp_addr", Address, 32'h14);
      tick();
      check("d0_pc",    DecPC, 32'hC);
      check("d0_count", {30'b0, FifoCount}, 32'd2);
      tick();
      check("d1_pc",    DecPC, 32'h10);
      check("d1_instr", DecInstr, 32'h1000_0004);
      check("d1_count", {30'b0, FifoCount}, 32'd2);
      // redirect with two entries queued
      RedirectValid = 1'b1; RedirectTarget = 32'h40;
      #1;
      check("rd_addr", Address, 32'h40);
      tick();
      RedirectValid = 1'b0;
      #1;
      check("rd_count", {30'b0, FifoCount}, 32'd0);
      check("rd_valid", {31'b0, DecValid}, 32'd0);
      check("rd_pcres", PCResult, 32'h40);
      check("rd_mis",   {31'b0, MisalignErr}, 32'd0);
      check("rd_next",  Address, 32'h44);
      tick();
      check("rd_headpc",  DecPC, 32'h40);
      check("rd_headpc4", DecPCPlus4, 32'h44);
      check("rd_instr",   DecInstr, 32'h1000_0010);
      // misaligned redirect
      RedirectValid = 1'b1; RedirectTarget = 32'h43;
      #1;
      check("ma_addr", Address, 32'h40);
      check("ma_pre",  {31'b0, MisalignErr}, 32'd0);
      tick();
      RedirectValid = 1'b0;
      #1;
      check("ma_pulse", {31'b0, MisalignErr}, 32'd1);
      check("ma_count", {30'b0, FifoCount}, 32'd0);
      tick();
      check("ma_clear", {31'b0, MisalignErr}, 32'd0);
      // PC wrap at top of address space
      RedirectValid = 1'b1; RedirectTarget = 32'hFFFF_FFFC;
      tick();
      RedirectValid = 1'b0;
      #1;
      check("wr_pcres", PCResult, 32'hFFFF_FFFC);
      check("wr_addr",  Address, 32'h0);
      tick();
      check("wr_headpc",  DecPC, 32'hFFFF_FFFC);
      check("wr_headpc4", DecPCPlus4, 32'h0);
      check("wr_instr",   DecInstr, 32'h4FFF_FFFF);
      check("wr_valid",   {31'b0, DecValid}, 32'd1);
      // asynchronous reset between edges
      #1 Reset = 1'b0;
      #1;
      check("ar_valid", {31'b0, DecValid}, 32'd0);
      check("ar_count", {30'b0, FifoCount}, 32'd0);
      check("ar_pc",    DecPC, 32'h0);
      check("ar_addr",  Address, 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
